// File: rtl/mul_div_pkg.sv
// Shared encodings for the sequential multiply/divide unit: op codes, FSM states, WIDTH limits.
package mul_div_pkg;

  localparam int unsigned WIDTH_MIN = 8;
  localparam int unsigned WIDTH_MAX = 64;
  localparam int unsigned CNT_W     = $clog2(WIDTH_MAX);

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add multiply step, or restoring shift-subtract
// divide step when MUL_DIV_SEQ_DIV_EN is defined.
module mul_div_step #(
  parameter int unsigned WIDTH = 32
) (
`ifdef MUL_DIV_SEQ_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_opnd,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;
`ifdef MUL_DIV_SEQ_DIV_EN
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
`endif

  always_comb begin
    w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    o_hi  = w_sum[WIDTH:1];
    o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};
`ifdef MUL_DIV_SEQ_DIV_EN
    // Bit WIDTH of the difference is the borrow: set means restore.
    w_rem_sh = {i_hi, i_lo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    if (i_div) begin
      o_hi = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end
`endif
  end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential signed/unsigned multiplier, with divider when MUL_DIV_SEQ_DIV_EN is defined.
// Fixed latency: result and done pulse WIDTH+2 edges after the accepting edge.
module mul_div_seq
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
  logic             r_neg_q, r_dbz_n, r_dbz, r_done;
`ifdef MUL_DIV_SEQ_DIV_EN
  logic             r_div, r_neg_r;
`endif
  op_t              w_op;
  logic             w_signed, w_is_div;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_step_hi, w_step_lo;

  assign w_op     = op_t'(op);
  assign w_signed = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign dbz  = r_dbz;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
`ifdef MUL_DIV_SEQ_DIV_EN
    .i_div  (r_div),
`endif
    .i_opnd (r_opnd),
    .i_hi   (r_acc_hi),
    .i_lo   (r_acc_lo),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) begin
`ifdef MUL_DIV_SEQ_DIV_EN
        w_next = (w_is_div && (b == '0)) ? ST_FIX : ST_RUN;
`else
        w_next = w_is_div ? ST_DONE : ST_RUN;
`endif
      end
      ST_RUN:  if (r_cnt == CNT_W'(WIDTH - 1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_dbz_n  <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
`ifdef MUL_DIV_SEQ_DIV_EN
      r_div    <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_cnt    <= '0;
          r_acc_hi <= '0;
          r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_dbz_n  <= 1'b0;
`ifdef MUL_DIV_SEQ_DIV_EN
          r_div    <= w_is_div;
          r_neg_r  <= w_signed & a[WIDTH-1];
          if (w_is_div) begin
            r_acc_lo <= w_a_mag;
            r_opnd   <= w_b_mag;
            // Zero divisor: preload the final result; FIX passes it through unchanged.
            if (b == '0) begin
              r_acc_hi <= a;
              r_acc_lo <= '1;
              r_neg_q  <= 1'b0;
              r_neg_r  <= 1'b0;
              r_dbz_n  <= 1'b1;
            end
          end else begin
            r_acc_lo <= w_b_mag;
            r_opnd   <= w_a_mag;
          end
`else
          r_acc_lo <= w_is_div ? '0 : w_b_mag;
          r_opnd   <= w_a_mag;
          r_dbz_n  <= w_is_div;
`endif
        end
        ST_RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_cnt    <= r_cnt + 1'b1;
        end
        ST_FIX: begin
`ifdef MUL_DIV_SEQ_DIV_EN
          if (r_div) begin
            if (r_neg_q) r_acc_lo <= -r_acc_lo;
            if (r_neg_r) r_acc_hi <= -r_acc_hi;
          end else if (r_neg_q) begin
            {r_acc_hi, r_acc_lo} <= -{r_acc_hi, r_acc_lo};
          end
`else
          if (r_neg_q) {r_acc_hi, r_acc_lo} <= -{r_acc_hi, r_acc_lo};
`endif
        end
        ST_DONE: begin
          r_hi   <= r_acc_hi;
          r_lo   <= r_acc_lo;
          r_dbz  <= r_dbz_n;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq at WIDTH=32 and WIDTH=8; division cases follow MUL_DIV_SEQ_DIV_EN.
module tb_mul_div_seq;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        st32 = 1'b0, st8 = 1'b0;
  logic [1:0]  op32 = 2'b00, op8 = 2'b00;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, dbz32, busy8, done8, dbz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  int          total = 0;
  int          bad = 0;
  int          lat;
  int          seen;

  always #5 clk = ~clk;

  mul_div_seq #(.WIDTH(32)) u_dut32 (
    .clock(clk), .clear(clear), .start(st32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .dbz(dbz32)
  );

  mul_div_seq #(.WIDTH(8)) u_dut8 (
    .clock(clk), .clear(clear), .start(st8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbz(dbz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept on the next rising edge; optionally pulse a competing start at accept+inj.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int inj, output int n);
    @(negedge clk);
    clear = 1'b1; st32 = 1'b1; op32 = o; a32 = x; b32 = y;
    @(posedge clk); #1;
    st32 = 1'b0;
    chk("busy_after_accept", busy32, 1'b1);
    n = 0;
    while (done32 !== 1'b1 && n < 100) begin
      if (n == inj - 1) begin
        st32 = 1'b1; op32 = 2'b01; a32 = 32'd7; b32 = 32'd7;
      end
      @(posedge clk); #1;
      st32 = 1'b0;
      n++;
    end
    chk("busy_at_done", busy32, 1'b0);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int n);
    @(negedge clk);
    st8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    st8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy32, 1'b0);
    chk("rst_done", done32, 1'b0);
    chk("rst_hi", hi32, 32'h0);
    chk("rst_lo", lo32, 32'h0);
    chk("rst_dbz", dbz32, 1'b0);

    // clear released and start raised together: accepted on the first edge
    run32(2'b01, 32'h00000034, 32'h00000045, 0, lat);
    chk("mulu_lat", lat, 34);
    chk("mulu_hi", hi32, 32'h00000000);
    chk("mulu_lo", lo32, 32'h00000E04);
    chk("mulu_dbz", dbz32, 1'b0);

    run32(2'b00, 32'hFFFFFFFD, 32'h00000005, 5, lat);
    chk("mul_neg_lat", lat, 34);
    chk("mul_neg_hi", hi32, 32'hFFFFFFFF);
    chk("mul_neg_lo", lo32, 32'hFFFFFFF1);
    @(posedge clk); #1;
    chk("done_one_cycle", done32, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_hi", hi32, 32'hFFFFFFFF);
    chk("hold_lo", lo32, 32'hFFFFFFF1);

    run32(2'b00, 32'h80000000, 32'h80000000, 0, lat);
    chk("mul_minmin_hi", hi32, 32'h40000000);
    chk("mul_minmin_lo", lo32, 32'h00000000);

    run32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat);
    chk("mulu_max_hi", hi32, 32'hFFFFFFFE);
    chk("mulu_max_lo", lo32, 32'h00000001);

`ifdef MUL_DIV_SEQ_DIV_EN
    run32(2'b10, 32'hFFFFFFF9, 32'h00000002, 0, lat);
    chk("div_lat", lat, 34);
    chk("div_lo", lo32, 32'hFFFFFFFD);
    chk("div_hi", hi32, 32'hFFFFFFFF);

    run32(2'b10, 32'h00000007, 32'hFFFFFFFE, 0, lat);
    chk("div_negb_lo", lo32, 32'hFFFFFFFD);
    chk("div_negb_hi", hi32, 32'h00000001);

    run32(2'b11, 32'd100, 32'd7, 0, lat);
    chk("divu_lo", lo32, 32'h0000000E);
    chk("divu_hi", hi32, 32'h00000002);

    run32(2'b11, 32'h12345678, 32'h0, 0, lat);
    chk("dbz_lat", lat, 2);
    chk("dbz_lo", lo32, 32'hFFFFFFFF);
    chk("dbz_hi", hi32, 32'h12345678);
    chk("dbz_flag", dbz32, 1'b1);

    run32(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, lat);
    chk("ovf_lat", lat, 34);
    chk("ovf_lo", lo32, 32'h80000000);
    chk("ovf_hi", hi32, 32'h00000000);
    chk("ovf_dbz", dbz32, 1'b0);
`else
    run32(2'b10, 32'h00000005, 32'h00000003, 0, lat);
    chk("ill_div_lat", lat, 1);
    chk("ill_div_dbz", dbz32, 1'b1);
    chk("ill_div_hi", hi32, 32'h0);
    chk("ill_div_lo", lo32, 32'h0);

    run32(2'b11, 32'h12345678, 32'h0, 0, lat);
    chk("ill_divu_lat", lat, 1);
    chk("ill_divu_dbz", dbz32, 1'b1);
`endif

    run32(2'b01, 32'd3, 32'd4, 0, lat);
    chk("dbz_cleared", dbz32, 1'b0);
    chk("small_lo", lo32, 32'd12);

    // asynchronous clear in the middle of an operation
    @(negedge clk);
    st32 = 1'b1; op32 = 2'b01; a32 = 32'd9; b32 = 32'd9;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk("clr_busy", busy32, 1'b0);
    chk("clr_hi", hi32, 32'h0);
    chk("clr_lo", lo32, 32'h0);
    chk("clr_dbz", dbz32, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32 === 1'b1) seen++;
    end
    chk("clr_no_done", seen, 0);
    chk("clr_idle_lo", lo32, 32'h0);

    run32(2'b01, 32'd2, 32'd3, 0, lat);
    chk("post_clr_lat", lat, 34);
    chk("post_clr_lo", lo32, 32'd6);

    run8(2'b01, 8'hFF, 8'hFF, lat);
    chk("w8_lat", lat, 10);
    chk("w8_hi", hi8, 8'hFE);
    chk("w8_lo", lo8, 8'h01);
    chk("w8_dbz", dbz8, 1'b0);

    run8(2'b00, 8'h80, 8'h7F, lat);
    chk("w8_mul_hi", hi8, 8'hC0);
    chk("w8_mul_lo", lo8, 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, legal range 8..64, even values only.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port clear, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2: 00 MUL signed, 01 MULU unsigned, 10 DIV signed, 11 DIVU unsigned.
REQ-006 SHALL have ports a and b, input, WIDTH each: multiplicand/dividend and multiplier/divisor.
REQ-007 SHALL have port busy, output, 1: high from the accepting edge until done is asserted.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the result is valid.
REQ-009 SHALL have ports hi and lo, output, WIDTH each: MUL gives product upper/lower halves; DIV gives remainder/quotient.
REQ-010 SHALL have port dbz, output, 1: divide-by-zero flag, valid while done is high and held until the next accept.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX, DONE; transitions IDLE->RUN on start, RUN->FIX after WIDTH iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-012 SHALL latch a, b and op on the accepting edge; later changes on a, b, op have no effect on the current operation.
REQ-013 SHALL ignore start in RUN, FIX and DONE; no queuing.
REQ-014 SHALL perform one iteration per cycle in RUN: radix-2 shift-add on operand magnitudes for MUL/MULU; restoring shift-subtract on magnitudes for DIV/DIVU.
REQ-015 SHALL apply sign correction in FIX: product negated if operand signs differ (signed MUL); quotient sign = sign(a) XOR sign(b), remainder sign = sign(a), truncation toward zero (signed DIV).
REQ-016 SHALL assert done and update hi/lo in DONE; fixed latency: done high exactly WIDTH+2 rising edges after the accepting edge.
REQ-017 SHALL hold hi, lo and dbz stable after DONE until the next accepted start; a new start is accepted in the cycle after done.
REQ-018 SHALL handle divisor zero (DIV/DIVU): skip RUN, go IDLE->FIX->DONE, done 2 edges after accept, lo = all ones, hi = a, dbz = 1.
REQ-019 SHALL handle signed overflow (most-negative / -1): lo = most-negative value, hi = 0, dbz = 0 (wrap-around).
REQ-020 SHALL produce the full 2*WIDTH product for MUL with no overflow flag.

Reset
REQ-021 SHALL, while clear is low, force state IDLE and busy=0, done=0, hi=0, lo=0, dbz=0 and clear internal accumulators, including mid-operation; no partial result is ever presented.
REQ-022 SHALL accept start on the first rising edge after clear deasserts.

Configuration
REQ-023 SHALL compile division hardware only when macro MUL_DIV_SEQ_DIV_EN is defined.
REQ-024 SHALL, without MUL_DIV_SEQ_DIV_EN, treat op 10/11 as illegal: IDLE->DONE, done 1 edge after accept, hi=lo=0, dbz=1; MUL/MULU timing unchanged.

Structure
REQ-025 SHALL take op encodings, FSM state encoding and the WIDTH legality limits from shared package mul_div_pkg.
REQ-026 SHALL isolate the per-iteration datapath (shift-add / shift-subtract step) in sub-module mul_div_step, combinational, instantiated once.

Verification
REQ-027 SHALL check WIDTH=32, MULU a=0x00000034 b=0x00000045 -> done at accept+34 edges, hi=0x00000000, lo=0x00000E04, dbz=0.
REQ-028 SHALL check MUL a=0xFFFFFFFD b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-029 SHALL check DIV a=0xFFFFFFF9 b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=0x0000000E, hi=0x00000002.
REQ-030 SHALL check DIVU a=0x12345678 b=0 -> done at accept+2 edges, lo=0xFFFFFFFF, hi=0x12345678, dbz=1; and DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 SHALL check start pulsed with new operands at accept+5 -> ignored, original result returned; clear low at accept+10 -> busy=0, hi=lo=0 immediately, no done pulse.
REQ-032 SHALL check, with MUL_DIV_SEQ_DIV_EN undefined, op=10 -> done at accept+1 edge, dbz=1, hi=lo=0; and WIDTH=8 MULU 0xFF*0xFF -> hi=0xFE, lo=0x01 at accept+10 edges.
